// File: rtl/pipelined_csa_adder.sv
// Parametrised, pipelined carry-select adder {c_out,sum} = a + b + c_in with valid/ready handshake.
// Build macro CSA_SELF_CHECK_EN adds a behavioural reference delay line and the err output.
module pipelined_csa_adder #(
    parameter int WIDTH  = 64,
    parameter int BLOCK  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef CSA_SELF_CHECK_EN
    ,
    output logic             err
`endif
);

    localparam int NB       = WIDTH / BLOCK;
    localparam int STG_SAFE = (STAGES > 0) ? STAGES : 1;
    localparam int BASE     = NB / STG_SAFE;
    localparam int EXTRA    = NB % STG_SAFE;

    if (WIDTH % BLOCK != 0 || STAGES < 1 || STAGES > NB) begin : g_param_check
        $error("pipelined_csa_adder: illegal WIDTH/BLOCK/STAGES combination");
    end

    // First block index owned by stage s; the remainder blocks go to the lowest stages.
    function automatic int blk_lo(input int s);
        return s * BASE + ((s < EXTRA) ? s : EXTRA);
    endfunction

    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0]            carry_q, carry_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;

    // Index 0 is the input port, index s+1 is the register after stage s.
    logic [STAGES:0]              src_valid_s, src_carry_s;
    logic [STAGES:0][WIDTH-1:0]   src_a_s, src_b_s, src_sum_s;

    assign src_valid_s = {valid_q, in_valid};
    assign src_carry_s = {carry_q, c_in};
    assign src_a_s     = {a_q, a};
    assign src_b_s     = {b_q, b};
    assign src_sum_s   = {sum_q, {WIDTH{1'b0}}};

    assign out_valid = valid_q[STAGES-1];
    assign in_ready  = !out_valid || out_ready;
    assign sum       = sum_q[STAGES-1];
    assign c_out     = carry_q[STAGES-1];

    // Per-stage carry-select evaluation; a stage only reloads when its upstream holds valid data.
    always_comb begin : comb_stages
        logic [WIDTH-1:0] acc;
        logic             cy;
        logic [BLOCK:0]   r0, r1, sel;
        valid_d = valid_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        acc     = {WIDTH{1'b0}};
        cy      = 1'b0;
        r0      = {(BLOCK+1){1'b0}};
        r1      = {(BLOCK+1){1'b0}};
        sel     = {(BLOCK+1){1'b0}};
        if (in_ready) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_d[s] = src_valid_s[s];
                if (src_valid_s[s]) begin
                    acc = src_sum_s[s];
                    cy  = src_carry_s[s];
                    for (int k = 0; k < NB; k++) begin
                        if (k >= blk_lo(s) && k < blk_lo(s + 1)) begin
                            // Block 0 ripples c_in in; upper blocks precompute both carry-in cases.
                            r0 = {1'b0, src_a_s[s][k*BLOCK +: BLOCK]} + {1'b0, src_b_s[s][k*BLOCK +: BLOCK]}
                               + ((k == 0) ? {{BLOCK{1'b0}}, cy} : {(BLOCK+1){1'b0}});
                            r1 = {1'b0, src_a_s[s][k*BLOCK +: BLOCK]} + {1'b0, src_b_s[s][k*BLOCK +: BLOCK]}
                               + {{BLOCK{1'b0}}, 1'b1};
                            sel = (k == 0 || !cy) ? r0 : r1;
                            acc[k*BLOCK +: BLOCK] = sel[BLOCK-1:0];
                            cy  = sel[BLOCK];
                        end else begin
                        end
                    end
                    a_d[s]     = src_a_s[s];
                    b_d[s]     = src_b_s[s];
                    sum_d[s]   = acc;
                    carry_d[s] = cy;
                end else begin
                end
            end
        end else begin
        end
    end

    // Pipeline registers with global stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

`ifdef CSA_SELF_CHECK_EN
    logic [STAGES-1:0][WIDTH:0] ref_q, ref_d;
    logic [STAGES:0][WIDTH:0]   src_ref_s;
    logic [STAGES-1:0]          cin_q, cin_d;
    logic [STAGES:0]            src_cin_s;
    logic                       err_q, err_d;

    assign src_ref_s = {ref_q, {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in}};
    assign src_cin_s = {cin_q, c_in};
    assign err       = err_q;

    // Reference delay line tracks the main pipeline; err is judged on the value entering the output stage.
    always_comb begin
        ref_d = ref_q;
        cin_d = cin_q;
        err_d = err_q;
        if (in_ready) begin
            for (int s = 0; s < STAGES; s++) begin
                if (src_valid_s[s]) begin
                    ref_d[s] = src_ref_s[s];
                    cin_d[s] = src_cin_s[s];
                end else begin
                end
            end
            err_d = src_valid_s[STAGES-1] && ({carry_d[STAGES-1], sum_d[STAGES-1]} != ref_d[STAGES-1]);
        end else begin
            err_d = err_q;
        end
    end

    // Reference and error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q <= '0;
            cin_q <= '0;
            err_q <= 1'b0;
        end else begin
            ref_q <= ref_d;
            cin_q <= cin_d;
            err_q <= err_d;
        end
    end

`ifndef SYNTHESIS
    // Report the offending operands while err is raised.
    always_ff @(posedge clk) begin
        if (err_q) begin
            $display("csa self-check error: a=%h b=%h c_in=%b", a_q[STAGES-1], b_q[STAGES-1], cin_q[STAGES-1]);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_pipelined_csa_adder.sv
// Self-checking bench for pipelined_csa_adder: directed table, stall/reset sequences and
// randomized streams against a plain-arithmetic queue model, on a 64/8/2 and a 32/4/3 instance.
module tb_pipelined_csa_adder;

    localparam int W  = 64;
    localparam int W2 = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid, in_ready, c_in, out_valid, out_ready, c_out;
    logic [W-1:0]  a, b, sum;
    logic          in_valid2, in_ready2, c_in2, out_valid2, out_ready2, c_out2;
    logic [W2-1:0] a2, b2, sum2;
`ifdef CSA_SELF_CHECK_EN
    logic          err, err2;
`endif

    pipelined_csa_adder #(.WIDTH(W), .BLOCK(8), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out)
`ifdef CSA_SELF_CHECK_EN
        , .err(err)
`endif
    );

    pipelined_csa_adder #(.WIDTH(W2), .BLOCK(4), .STAGES(3)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .c_in(c_in2), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .c_out(c_out2)
`ifdef CSA_SELF_CHECK_EN
        , .err(err2)
`endif
    );

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vc;
        logic [W-1:0] exp_sum;
        logic         exp_c;
    } vec_t;

    int           checks = 0;
    int           failures = 0;
    logic [W:0]   exp_q[$];
    logic [W2:0]  exp2_q[$];
    logic         stall_prev = 1'b0;
    logic [W:0]   held;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + (W+1)'(c);
    endfunction

    function automatic logic [W2:0] model2(input logic [W2-1:0] x, input logic [W2-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + (W2+1)'(c);
    endfunction

    // One cycle on the 64-bit instance; entered and left just after a rising edge.
    task automatic step1(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input logic ordy, output logic acc);
        in_valid = iv; a = ia; b = ib; c_in = ic; out_ready = ordy;
        #1;
        if (stall_prev) begin
            check_bit("stall_valid", out_valid, 1'b1);
            check("stall_hold", {c_out, sum}, held);
        end
        if (out_valid && !ordy) check_bit("in_ready_stalled", in_ready, 1'b0);
        else                    check_bit("in_ready_open", in_ready, 1'b1);
`ifdef CSA_SELF_CHECK_EN
        check_bit("err", err, 1'b0);
`endif
        if (out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%h required=none", {c_out, sum});
            end else begin
                check("result", {c_out, sum}, exp_q.pop_front());
            end
        end
        acc = iv && in_ready;
        if (acc) exp_q.push_back(model(ia, ib, ic));
        stall_prev = out_valid && !ordy;
        held = {c_out, sum};
        @(posedge clk); #1;
    endtask

    // One cycle on the 32-bit instance.
    task automatic step2(input logic iv, input logic [W2-1:0] ia, input logic [W2-1:0] ib,
                         input logic ic, input logic ordy, output logic acc);
        in_valid2 = iv; a2 = ia; b2 = ib; c_in2 = ic; out_ready2 = ordy;
        #1;
        if (out_valid2 && !ordy) check_bit("in_ready2_stalled", in_ready2, 1'b0);
        else                     check_bit("in_ready2_open", in_ready2, 1'b1);
`ifdef CSA_SELF_CHECK_EN
        check_bit("err2", err2, 1'b0);
`endif
        if (out_valid2 && ordy) begin
            if (exp2_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output2 actual=%h required=none", {c_out2, sum2});
            end else begin
                check("result2", (W+1)'({c_out2, sum2}), (W+1)'(exp2_q.pop_front()));
            end
        end
        acc = iv && in_ready2;
        if (acc) exp2_q.push_back(model2(ia, ib, ic));
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t         vecs[8];
        logic         acc, rv, rc, ordy;
        logic [W-1:0] ra, rb;
        logic [W2-1:0] ra2, rb2;
        int           lat, sent, cyc;

        vecs[0] = '{64'h0000000000000001, 64'h0000000000000001, 1'b0, 64'h0000000000000002, 1'b0};
        vecs[1] = '{64'hFFFFFFFFFFFFFFFF, 64'h0000000000000001, 1'b0, 64'h0000000000000000, 1'b1};
        vecs[2] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[3] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b1, 64'h0000000000000000, 1'b1};
        vecs[4] = '{64'h00000000FFFFFFFF, 64'h0000000000000001, 1'b0, 64'h0000000100000000, 1'b0};
        vecs[5] = '{64'h8000000000000000, 64'h8000000000000000, 1'b0, 64'h0000000000000000, 1'b1};
        vecs[6] = '{64'h0000000000000000, 64'h0000000000000000, 1'b1, 64'h0000000000000001, 1'b0};
        vecs[7] = '{64'h00000000000000FF, 64'h0000000000000000, 1'b1, 64'h0000000000000100, 1'b0};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; c_in2 = 1'b0; out_ready2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_bit("reset_out_valid", out_valid, 1'b0);
        check("reset_sum", {c_out, sum}, '0);
        check_bit("reset_out_valid2", out_valid2, 1'b0);
        check("reset_sum2", (W+1)'({c_out2, sum2}), '0);

        // Directed table: value and latency on an otherwise empty pipeline.
        for (int i = 0; i < 8; i++) begin
            step1(1'b1, vecs[i].va, vecs[i].vb, vecs[i].vc, 1'b1, acc);
            check_bit("table_accept", acc, 1'b1);
            lat = 1;
            while (!out_valid && lat < 10) begin
                step1(1'b0, '0, '0, 1'b0, 1'b1, acc);
                lat++;
            end
            check_int("table_latency", lat, 2);
            check("table_value", {c_out, sum}, {vecs[i].exp_c, vecs[i].exp_sum});
            step1(1'b0, '0, '0, 1'b0, 1'b1, acc);
        end
        step1(1'b0, '0, '0, 1'b0, 1'b1, acc);
        check_bit("empty_out_valid", out_valid, 1'b0);
        check("empty_hold", {c_out, sum}, {vecs[7].exp_c, vecs[7].exp_sum});

        // Back-to-back streams with the output held off for the first 5 cycles.
        for (int n = 3; n <= 5; n++) begin
            sent = 0; cyc = 0;
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = 1'(($urandom));
            while ((sent < n || exp_q.size() > 0) && cyc < 60) begin
                step1(sent < n, ra, rb, rc, cyc >= 5, acc);
                if (acc) begin
                    sent++;
                    ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = 1'(($urandom));
                end
                cyc++;
            end
            check_int("stream_sent", sent, n);
            check_int("stream_drained", exp_q.size(), 0);
        end

        // Reset with two operations in flight discards both.
        step1(1'b1, 64'h1111111111111111, 64'h2222222222222222, 1'b0, 1'b1, acc);
        step1(1'b1, 64'h3333333333333333, 64'h4444444444444444, 1'b1, 1'b1, acc);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_bit("rst_flight_valid", out_valid, 1'b0);
        check("rst_flight_sum", {c_out, sum}, '0);
        exp_q.delete();
        stall_prev = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_bit("no_stale", out_valid, 1'b0);
            step1(1'b0, '0, '0, 1'b0, 1'b1, acc);
        end

        // Random traffic with random backpressure.
        rv = 1'b0; acc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!rv || acc) begin
                rv = ($urandom_range(0, 9) < 7);
                rc = 1'(($urandom));
                ra = {$urandom, $urandom};
                case ($urandom_range(0, 3))
                    0:       rb = {$urandom, $urandom};
                    1:       begin ra = '1; rb = (W)'(rc ? 0 : 1); end
                    2:       rb = ~ra;
                    default: rb = {$urandom, $urandom};
                endcase
            end
            ordy = ($urandom_range(0, 9) < 6);
            step1(rv, ra, rb, rc, ordy, acc);
        end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 20) begin
            step1(1'b0, '0, '0, 1'b0, 1'b1, acc);
            cyc++;
        end
        check_int("random_drained", exp_q.size(), 0);

        // Uneven block split (3/3/2) on the 32-bit instance.
        step2(1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, acc);
        lat = 1;
        while (!out_valid2 && lat < 10) begin
            step2(1'b0, '0, '0, 1'b0, 1'b1, acc);
            lat++;
        end
        check_int("latency2", lat, 3);
        check("wrap2", (W+1)'({c_out2, sum2}), (W+1)'(33'h100000000));
        step2(1'b0, '0, '0, 1'b0, 1'b1, acc);
        rv = 1'b0; acc = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!rv || acc) begin
                rv = ($urandom_range(0, 3) != 0);
                ra2 = $urandom;
                rb2 = (i % 5 == 0) ? ~ra2 : $urandom;
                rc = 1'(($urandom));
            end
            ordy = ($urandom_range(0, 2) != 0);
            step2(rv, ra2, rb2, rc, ordy, acc);
        end
        cyc = 0;
        while (exp2_q.size() > 0 && cyc < 20) begin
            step2(1'b0, '0, '0, 1'b0, 1'b1, acc);
            cyc++;
        end
        check_int("random2_drained", exp2_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
